// File: rtl/mem_access_unit_if.sv
// Pipeline-side and memory-side signals of the load/store access unit.
// The slave modport is the access unit; the master modport is the pipeline plus memory.
interface mem_access_unit_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  req, op, addr, wdata, mem_rdata, mem_ack,
        output busy, done, rdata, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req, op, addr, wdata, mem_rdata, mem_ack,
        input  busy, done, rdata, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store access unit: one memory access in flight, lane steering, load extension, ack timeout.
// Define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned word/half accesses with err=01.
module mem_access_unit #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [7:0] CntLast = 8'(ACK_TIMEOUT - 1);

    state_e      state_q;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [7:0]  cnt_q;
    logic        busy_q, done_q, mem_req_q, mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
    logic [1:0]  err_q;

    logic        is_store_d, is_store_q;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    always_comb begin
        is_store_d = bus.op[2] & (bus.op[1] | bus.op[0]);
        be_d       = 4'b1111;
        wdata_d    = 32'h0;
        case (bus.op)
            3'b000, 3'b101: begin
                be_d    = 4'b1111;
                wdata_d = bus.wdata;
            end
            3'b001, 3'b010, 3'b110: begin
                be_d    = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{bus.wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b0001 << bus.addr[1:0];
                wdata_d = {4{bus.wdata[7:0]}};
            end
        endcase
        if (!is_store_d) wdata_d = 32'h0;
    end

    assign is_store_q = op_q[2] & (op_q[1] | op_q[0]);

    always_comb begin
        ld_byte = bus.mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (op_q)
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b010:  load_ext = {16'h0, ld_half};
            3'b011:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'h0, ld_byte};
            default: load_ext = bus.mem_rdata;
        endcase
    end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic misalign_d, misalign_q;

    always_comb begin
        case (bus.op)
            3'b000, 3'b101:         misalign_d = |bus.addr[1:0];
            3'b001, 3'b010, 3'b110: misalign_d = bus.addr[0];
            default:                misalign_d = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= 3'b000;
            lane_q      <= 2'b00;
            cnt_q       <= 8'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 2'b00;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        state_q     <= StAccess;
                        op_q        <= bus.op;
                        lane_q      <= bus.addr[1:0];
                        cnt_q       <= 8'h0;
                        busy_q      <= 1'b1;
                        mem_we_q    <= is_store_d;
                        mem_be_q    <= be_d;
                        mem_addr_q  <= {bus.addr[31:2], 2'b00};
                        mem_wdata_q <= wdata_d;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                        // A rejected access still spends one busy cycle here, without mem_req.
                        misalign_q  <= misalign_d;
                        mem_req_q   <= ~misalign_d;
`else
                        mem_req_q   <= 1'b1;
`endif
                    end
                end
                StAccess: begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                    if (misalign_q) begin
                        err_q   <= 2'b01;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else
`endif
                    // Ack takes priority over a simultaneous timeout.
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 2'b00;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                        if (!is_store_q) rdata_q <= load_ext;
                    end else if (cnt_q == CntLast) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 2'b10;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 8'h1;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model plus per-cycle compare.
module tb_mem_access_unit;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(.ACK_TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    bit          chk_on;
    logic        e_busy, e_done, e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdata, m_rdata;
    logic [1:0]  e_err;

    int          obs_lat, obs_req_cycles;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;
    logic [1:0]  obs_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sz_of(input logic [2:0] o);
        case (o)
            3'd0, 3'd5:       return 4;
            3'd1, 3'd2, 3'd6: return 2;
            default:          return 1;
        endcase
    endfunction

    function automatic bit is_st(input logic [2:0] o);
        return o >= 3'd5;
    endfunction

    function automatic bit m_misaligned(input logic [2:0] o, input logic [31:0] a);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        return (a % 32'(sz_of(o))) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] wd);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_extend(input logic [2:0] o, input int lane,
                                             input logic [31:0] w);
        int sz;
        logic [31:0] mask, v;
        sz   = sz_of(o);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = (w >> (8 * lane)) & mask;
        if ((o == 3'd1 || o == 3'd3) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", 32'(bus.busy), 32'(e_busy));
            check("done", 32'(bus.done), 32'(e_done));
            check("mem_req", 32'(bus.mem_req), 32'(e_req));
            check("rdata", bus.rdata, e_rdata);
            if (e_req) begin
                check("mem_we", 32'(bus.mem_we), 32'(e_we));
                check("mem_be", 32'(bus.mem_be), 32'(e_be));
                check("mem_addr", bus.mem_addr, e_addr);
                if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
            end
            if (e_done) check("err", 32'(bus.err), 32'(e_err));
        end
    end

    // ack_at: ACCESS cycle (1-based) carrying mem_ack, 0 = never. hold keeps req high while busy.
    task automatic do_txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_at, input bit hold);
        int sz, lane, n;
        bit mis, tout;
        logic [31:0] new_hold;
        sz   = sz_of(o);
        lane = (int'(a % 4) / sz) * sz;
        mis  = m_misaligned(o, a);
        tout = !mis && !(ack_at >= 1 && ack_at <= T);
        n    = mis ? 1 : (tout ? T : ack_at);
        new_hold = m_rdata;
        if (!mis && !tout && !is_st(o)) new_hold = m_extend(o, lane, rd);
        e_be    = 4'(((1 << sz) - 1) << lane);
        e_addr  = {a[31:2], 2'b00};
        e_we    = is_st(o);
        e_wdata = m_wdata(sz, wd);
        e_err   = mis ? 2'b01 : (tout ? 2'b10 : 2'b00);
        obs_lat = -1;
        obs_req_cycles = 0;
        for (int j = 0; j <= n + 2; j++) begin
            @(posedge clk);
            #1;
            bus.req       = (j == 0) || (hold && j <= n + 1);
            bus.op        = (j == 0) ? o : o ^ 3'b011;
            bus.addr      = (j == 0) ? a : ~a;
            bus.wdata     = (j == 0) ? wd : ~wd;
            bus.mem_ack   = (!mis && j == ack_at && j >= 1 && j <= n) || (j >= n + 1);
            bus.mem_rdata = (j == ack_at) ? rd : 32'h5A5A_A5A5;
            e_busy = (j >= 1) && (j <= n + 1);
            e_done = (j == n + 1);
            e_req  = !mis && (j >= 1) && (j <= n);
            if (j == n + 1) m_rdata = new_hold;
            e_rdata = m_rdata;
            @(negedge clk);
            if (bus.mem_req) obs_req_cycles++;
            if (j == 1) begin
                obs_be    = bus.mem_be;
                obs_addr  = bus.mem_addr;
                obs_wdata = bus.mem_wdata;
                obs_we    = bus.mem_we;
            end
            if (bus.done && obs_lat < 0) begin
                obs_lat   = j;
                obs_rdata = bus.rdata;
                obs_err   = bus.err;
            end
        end
        bus.req     = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check({tag, "_done"}, 32'(bus.done), 32'h0);
        check({tag, "_mem_req"}, 32'(bus.mem_req), 32'h0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'h0);
        check({tag, "_mem_be"}, 32'(bus.mem_be), 32'h0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_rdata"}, bus.rdata, 32'h0);
        check({tag, "_err"}, 32'(bus.err), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        chk_on = 1'b1;
        bus.req = 1'b0; bus.op = 3'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
        bus.mem_rdata = 32'h0; bus.mem_ack = 1'b0;
        e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0; e_we = 1'b0; e_be = 4'h0;
        e_addr = 32'h0; e_wdata = 32'h0; e_rdata = 32'h0; m_rdata = 32'h0; e_err = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        // Stray ack while idle must not start anything.
        @(posedge clk); #1; bus.mem_ack = 1'b1;
        @(posedge clk); #1; bus.mem_ack = 1'b0;

        do_txn(3'd0, 32'h100, 32'h0, 32'hDEAD_BEEF, 4, 1'b0);
        check("lw_latency", 32'(obs_lat), 32'd5);
        check("lw_rdata", obs_rdata, 32'hDEAD_BEEF);
        check("lw_be", 32'(obs_be), 32'hF);
        check("lw_addr", obs_addr, 32'h100);
        check("lw_err", 32'(obs_err), 32'h0);

        do_txn(3'd3, 32'h103, 32'h0, 32'h80FF_1234, 1, 1'b0);
        check("lb_latency", 32'(obs_lat), 32'd2);
        check("lb_be", 32'(obs_be), 32'h8);
        check("lb_rdata", obs_rdata, 32'hFFFF_FF80);
        do_txn(3'd4, 32'h103, 32'h0, 32'h80FF_1234, 2, 1'b0);
        check("lbu_rdata", obs_rdata, 32'h0000_0080);
        do_txn(3'd1, 32'h102, 32'h0, 32'h80FF_1234, 1, 1'b1);
        check("lh_rdata", obs_rdata, 32'hFFFF_80FF);
        do_txn(3'd2, 32'h100, 32'h0, 32'h80FF_9234, 3, 1'b1);
        check("lhu_rdata", obs_rdata, 32'h0000_9234);

        do_txn(3'd6, 32'h202, 32'h0000_ABCD, 32'h0, 1, 1'b0);
        check("sh_we", 32'(obs_we), 32'h1);
        check("sh_be", 32'(obs_be), 32'hC);
        check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        check("sh_addr", obs_addr, 32'h200);
        do_txn(3'd7, 32'h201, 32'h1234_56EF, 32'h0, 2, 1'b1);
        check("sb_wdata", obs_wdata, 32'hEFEF_EFEF);
        do_txn(3'd5, 32'h300, 32'hCAFE_F00D, 32'h0, 1, 1'b0);

        do_txn(3'd0, 32'h104, 32'h0, 32'h1357_9BDF, 0, 1'b0);
        check("timeout_req_cycles", 32'(obs_req_cycles), 32'd16);
        check("timeout_err", 32'(obs_err), 32'h2);
        check("timeout_latency", 32'(obs_lat), 32'd17);
        do_txn(3'd0, 32'h108, 32'h0, 32'h2468_ACE0, 16, 1'b0);
        check("ack16_err", 32'(obs_err), 32'h0);
        check("ack16_rdata", obs_rdata, 32'h2468_ACE0);

        do_txn(3'd5, 32'h101, 32'h7766_5544, 32'h0, 1, 1'b0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        check("misalign_req_cycles", 32'(obs_req_cycles), 32'd0);
        check("misalign_latency", 32'(obs_lat), 32'd2);
        check("misalign_err", 32'(obs_err), 32'h1);
`else
        check("unaligned_sw_be", 32'(obs_be), 32'hF);
        check("unaligned_sw_addr", obs_addr, 32'h100);
        check("unaligned_sw_err", 32'(obs_err), 32'h0);
`endif
        do_txn(3'd1, 32'h101, 32'h0, 32'h0000_8001, 1, 1'b0);

        // Reset in the middle of a store access.
        chk_on = 1'b0;
        @(posedge clk); #1;
        bus.req = 1'b1; bus.op = 3'd5; bus.addr = 32'h400; bus.wdata = 32'h1122_3344;
        @(posedge clk); #1; bus.req = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_mem_req", 32'(bus.mem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("mid_access_reset");
        @(posedge clk); #1; rst_n = 1'b1; bus.mem_ack = 1'b1;
        m_rdata = 32'h0;
        e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0; e_rdata = 32'h0;
        chk_on = 1'b1;
        @(posedge clk); #1; bus.mem_ack = 1'b0;
        repeat (4) @(posedge clk);
        do_txn(3'd0, 32'h500, 32'h0, 32'h0BAD_F00D, 1, 1'b0);
        check("post_reset_rdata", obs_rdata, 32'h0BAD_F00D);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
